chunked_adder_sub: RTL

Parametrised multi-cycle adder/subtractor; successor to the 32-bit combinational full adder in arithmetic unit A. Processes a WIDTH-bit operation in CHUNK-bit slices, least significant first, with the carry rippled through a register between cycles. Adds subtraction, an overflow flag and a valid/ready handshake on both sides. Supplies the ALU datapath with the result and the N/Z/C/V flags.

---
 rtl/chunked_adder_sub.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/chunked_adder_sub.sv
// Multi-cycle adder/subtractor: a WIDTH-bit operation is processed CHUNK bits per
// cycle, least significant slice first, with the carry held in a register between slices.
module chunked_adder_sub #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             n,
  output logic             z,
  output logic             v
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NCH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg;
  logic [KW-1:0]    k_reg;
  logic             carry_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] s_reg;
  logic             c_out_reg;
  logic             n_reg;
  logic             z_reg;
  logic             v_reg;
  logic             in_ready_reg;
  logic             out_valid_reg;

  logic [CHUNK-1:0] a_slice [NCH];
  logic [CHUNK-1:0] b_slice [NCH];
  logic [CHUNK-1:0] a_sel;
  logic [CHUNK-1:0] b_sel;
  logic [CHUNK:0]   chunk_sum;
  logic [WIDTH-1:0] s_next;
  logic             last_chunk;

  // b_reg already holds ~B for subtraction, so every slice is a plain add.
  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_slice
      assign a_slice[gi] = a_reg[gi*CHUNK +: CHUNK];
      assign b_slice[gi] = b_reg[gi*CHUNK +: CHUNK];
      assign s_next[gi*CHUNK +: CHUNK] = (k_reg == KW'(gi)) ? chunk_sum[CHUNK-1:0]
                                                           : s_reg[gi*CHUNK +: CHUNK];
    end
  endgenerate

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NCH; i++) begin
      if (k_reg == KW'(i)) begin
        a_sel = a_slice[i];
        b_sel = b_slice[i];
      end
    end
  end

  assign chunk_sum  = {1'b0, a_sel} + {1'b0, b_sel} + (CHUNK+1)'(carry_reg);
  assign last_chunk = (k_reg == K_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      k_reg         <= '0;
      carry_reg     <= 1'b0;
      a_reg         <= '0;
      b_reg         <= '0;
      s_reg         <= '0;
      c_out_reg     <= 1'b0;
      n_reg         <= 1'b0;
      z_reg         <= 1'b0;
      v_reg         <= 1'b0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_reg        <= a;
            b_reg        <= sub ? ~b : b;
            carry_reg    <= c_in ^ sub;
            k_reg        <= '0;
            in_ready_reg <= 1'b0;
            state_reg    <= RUN;
          end
        end
        RUN: begin
          s_reg     <= s_next;
          carry_reg <= chunk_sum[CHUNK];
          if (last_chunk) begin
            // Flags are taken from s_next so the final slice is included.
            c_out_reg     <= chunk_sum[CHUNK];
            n_reg         <= s_next[WIDTH-1];
            z_reg         <= (s_next == '0);
            v_reg         <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                             (s_next[WIDTH-1] != a_reg[WIDTH-1]);
            out_valid_reg <= 1'b1;
            state_reg     <= DONE;
          end else begin
            k_reg <= k_reg + KW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: begin
          out_valid_reg <= 1'b0;
          in_ready_reg  <= 1'b1;
          state_reg     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign s         = s_reg;
  assign c_out     = c_out_reg;
  assign n         = n_reg;
  assign z         = z_reg;
  assign v         = v_reg;

endmodule
